pipelined_wide_adder: RTL and testbench
=======================================

// Module: pipelined_wide_adder
// PURPOSE
//  Parametrised pipelined WIDTH-bit adder: each stage adds one CHUNK-bit slice plus the registered
//  carry from the stage below, so carry never ripples more than CHUNK bits per cycle.
//  Next generation of the fixed-width combinational slice adders: arbitrary width, carry-in,
//  valid/ready flow control, one result per cycle. Core datapath of the parallel 128-bit adder top.
// PARAMETERS
//  WIDTH   128  operand width in bits; must be an integer multiple of CHUNK
//  CHUNK   8    bits added per pipeline stage; local STAGES = WIDTH/CHUNK is the pipeline depth
// PORTS
//  clk        in   1          sole clock, all state on rising edge
//  rst        in   1          synchronous, active-high reset
//  in_valid   in   1          operands a, b, cin valid this cycle
//  in_ready   out  1          adder can accept operands this cycle
//  a          in   WIDTH      operand A (unsigned)
//  b          in   WIDTH      operand B (unsigned)
//  cin        in   1          carry into bit 0
//  out_valid  out  1          sum/cout valid
//  out_ready  in   1          downstream accepts result this cycle
//  sum        out  WIDTH      result bits [WIDTH-1:0]
//  cout       out  1          carry out of bit WIDTH-1; {cout,sum} = a+b+cin, WIDTH+1 bits total
// BEHAVIOUR
//  - One clock (clk); reset is synchronous and active-high (rst); no async paths.
//  - Reset: out_valid=0, sum=0, cout=0, every stage valid bit and data register cleared.
//    A reset mid-operation discards all in-flight operations; nothing emerges after reset.
//  - Stage k (0..STAGES-1) registers chunk k: {c,s} = a[k] + b[k] + carry_k; carry_0 = cin,
//    carry_k = registered carry of stage k-1. Upper unprocessed chunks travel in skew registers;
//    completed lower chunks travel in deskew registers; stage STAGES-1 drives sum/cout directly.
//  - Latency: exactly STAGES cycles from accept (in_valid&in_ready at edge N) to out_valid at N+STAGES,
//    absent backpressure. CHUNK==WIDTH gives latency 1. Throughput 1 op/cycle.
//  - Flow control: stall = out_valid & ~out_ready. in_ready = ~stall (combinational, no dependency on
//    in_valid). On stall the whole pipeline, incl. bubbles, holds; sum/cout stable while out_valid&~out_ready.
//  - Accept and output-fire in the same cycle: both happen; pipeline advances one step.
//  - Bubbles: in_valid=0 while in_ready=1 injects an invalid stage; data regs may update but valid=0.
//  - in_valid while in_ready=0: operands ignored; source must hold them (standard valid/ready).
//  - Order preserved; no result dropped or duplicated. Wrap-around: a+b+cin >= 2^WIDTH sets cout=1
//    and sum = low WIDTH bits (e.g. all-ones + 1 -> sum 0, cout 1).
//  - WIDTH % CHUNK != 0: elaboration error ($error in generate block).
// CONFIGURATION
//  ADDER_SUB_EN: when defined, adds input port sub (1 bit, sampled with a/b on accept, carried down
//    the pipeline with its op). sub=1 computes a + ~b + 1 (cin ignored); cout=1 means no borrow
//    (a >= b). sub=0 behaves exactly as the non-macro build.
//  Undefined: no sub port; add-only datapath as above.
// TESTING  (default WIDTH=128, CHUNK=8, STAGES=16 unless noted)
//  1 a=2^128-1, b=0, cin=1, out_ready=1 -> 16 cycles later sum=0, cout=1, out_valid one cycle only.
//  2 back-to-back 32 random ops, out_ready=1 -> 32 consecutive results from cycle 16, all match
//    a+b+cin model, in_ready stays 1.
//  3 8 ops in flight, out_ready=0 for 10 cycles -> in_ready=0 after first result, sum/cout held
//    stable, pipeline frozen; release -> remaining results in order, none lost or repeated.
//  4 5 ops accepted, rst=1 for 1 cycle at cycle 7 -> out_valid=0, sum=0, cout=0 next cycle;
//    no result for those ops ever appears; new op after reset returns in 16 cycles.
//  5 WIDTH=16, CHUNK=16: a=16'hFFFF, b=16'h0001, cin=0 -> latency 1, sum=16'h0000, cout=1.
//  6 ADDER_SUB_EN: sub=1, a=5, b=7 -> sum=2^128-2, cout=0; sub=1, a=7, b=5 -> sum=2, cout=1.

Source files
------------

// File: rtl/pipelined_wide_adder_if.sv
// pipelined_wide_adder_if: valid/ready operand and result bundle for the pipelined wide adder.
//   in_valid/in_ready  operand handshake (a, b, cin, and sub when ADDER_SUB_EN is defined)
//   out_valid/out_ready result handshake (sum, cout)
//   master: the side that supplies operands and consumes results; slave: the adder.
interface pipelined_wide_adder_if #(
    parameter int WIDTH = 128
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef ADDER_SUB_EN
    logic             sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;

`ifdef ADDER_SUB_EN
    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout
    );
    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout
    );
`else
    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout
    );
    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout
    );
`endif
endinterface

// File: rtl/pipelined_wide_adder.sv
// pipelined_wide_adder: WIDTH-bit adder pipelined CHUNK bits per stage with valid/ready flow control.
//   clk   sole clock, rising edge
//   rst   synchronous active-high reset, clears every stage
//   bus   pipelined_wide_adder_if.slave: in_valid/in_ready/a/b/cin in, out_valid/out_ready/sum/cout out
// Optional feature macro ADDER_SUB_EN: adds bus.sub; sub=1 computes a + ~b + 1 (cout=1 means no borrow).
module pipelined_wide_adder #(
    parameter int WIDTH = 128,
    parameter int CHUNK = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    pipelined_wide_adder_if.slave bus
);
    localparam int STAGES = WIDTH / CHUNK;

    if (WIDTH % CHUNK != 0) begin : g_bad_chunk
        $error("pipelined_wide_adder: WIDTH must be a multiple of CHUNK");
    end

    // Per-stage registers: a_q/b_q carry operands not yet consumed (skew),
    // s_q accumulates finished sum chunks (deskew), c_q is the inter-stage carry.
    logic             v_q [STAGES];
    logic             c_q [STAGES];
    logic [WIDTH-1:0] a_q [STAGES];
    logic [WIDTH-1:0] b_q [STAGES];
    logic [WIDTH-1:0] s_q [STAGES];
    logic             v_i [STAGES];
    logic             c_i [STAGES];
    logic [WIDTH-1:0] a_i [STAGES];
    logic [WIDTH-1:0] b_i [STAGES];
    logic [WIDTH-1:0] s_i [STAGES];
    logic [WIDTH-1:0] s_n [STAGES];
    logic [CHUNK-1:0] bx  [STAGES];
    logic [CHUNK:0]   r   [STAGES];
    logic             stall;
`ifdef ADDER_SUB_EN
    logic             sb_q [STAGES];
    logic             sb_i [STAGES];
`endif

    // The whole pipeline, bubbles included, freezes while the output is blocked.
    assign stall         = v_q[STAGES-1] & ~bus.out_ready;
    assign bus.in_ready  = ~stall;
    assign bus.out_valid = v_q[STAGES-1];
    assign bus.sum       = s_q[STAGES-1];
    assign bus.cout      = c_q[STAGES-1];

    always_comb begin
        v_i[0] = bus.in_valid;
        a_i[0] = bus.a;
        b_i[0] = bus.b;
        s_i[0] = '0;
`ifdef ADDER_SUB_EN
        sb_i[0] = bus.sub;
        c_i[0]  = bus.sub | bus.cin;
`else
        c_i[0]  = bus.cin;
`endif
        for (int k = 1; k < STAGES; k++) begin
            v_i[k] = v_q[k-1];
            c_i[k] = c_q[k-1];
            a_i[k] = a_q[k-1];
            b_i[k] = b_q[k-1];
            s_i[k] = s_q[k-1];
`ifdef ADDER_SUB_EN
            sb_i[k] = sb_q[k-1];
`endif
        end
        for (int k = 0; k < STAGES; k++) begin
`ifdef ADDER_SUB_EN
            bx[k] = b_i[k][k*CHUNK +: CHUNK] ^ {CHUNK{sb_i[k]}};
`else
            bx[k] = b_i[k][k*CHUNK +: CHUNK];
`endif
            r[k] = {1'b0, a_i[k][k*CHUNK +: CHUNK]} + {1'b0, bx[k]} + {{CHUNK{1'b0}}, c_i[k]};
            s_n[k] = s_i[k];
            s_n[k][k*CHUNK +: CHUNK] = r[k][CHUNK-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k] <= 1'b0;
                c_q[k] <= 1'b0;
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
`ifdef ADDER_SUB_EN
                sb_q[k] <= 1'b0;
`endif
            end
        end else if (!stall) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k] <= v_i[k];
                c_q[k] <= r[k][CHUNK];
                a_q[k] <= a_i[k];
                b_q[k] <= b_i[k];
                s_q[k] <= s_n[k];
`ifdef ADDER_SUB_EN
                sb_q[k] <= sb_i[k];
`endif
            end
        end
    end
endmodule

// File: tb/tb_pipelined_wide_adder.sv
// tb_pipelined_wide_adder: directed self-checking bench for pipelined_wide_adder (128/8 and 16/16 builds).
module tb_pipelined_wide_adder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipelined_wide_adder_if #(.WIDTH(128)) p ();
    pipelined_wide_adder_if #(.WIDTH(16))  s ();

    pipelined_wide_adder #(.WIDTH(128), .CHUNK(8))  u0 (.clk(clk), .rst(rst), .bus(p.slave));
    pipelined_wide_adder #(.WIDTH(16),  .CHUNK(16)) u1 (.clk(clk), .rst(rst), .bus(s.slave));

    int total = 0;
    int bad = 0;
    int pops = 0;
    int lat;
    int n;
    int ghost;
    logic [128:0] q[$];

    function automatic logic [128:0] model();
`ifdef ADDER_SUB_EN
        if (p.sub) return {1'b0, p.a} + {1'b0, ~p.b} + 129'd1;
`endif
        return {1'b0, p.a} + {1'b0, p.b} + {128'd0, p.cin};
    endfunction

    task automatic check(input string tag, input logic [128:0] obs, input logic [128:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: record accept/fire just before the edge, then score any fired result.
    task automatic cycle();
        logic acc, fire;
        logic [128:0] got, e;
        #1;
        acc  = p.in_valid & p.in_ready & ~rst;
        fire = p.out_valid & p.out_ready & ~rst;
        got  = {p.cout, p.sum};
        if (acc) q.push_back(model());
        @(posedge clk);
        #1;
        if (fire) begin
            check("sb_pending", 129'(q.size() > 0), 129'd1);
            if (q.size() > 0) begin
                e = q.pop_front();
                check("sb_data", got, e);
                pops++;
            end
        end
    endtask

    // Counts cycles from the accept edge until out_valid, bounded.
    task automatic wait_out(output int l);
        l = 1;
        while (!p.out_valid && l < 40) begin
            cycle();
            l++;
        end
    endtask

    task automatic drive(input logic [127:0] av, input logic [127:0] bv, input logic c);
        p.in_valid = 1'b1;
        p.a = av;
        p.b = bv;
        p.cin = c;
    endtask

    initial begin
        p.in_valid = 1'b0; p.a = '0; p.b = '0; p.cin = 1'b0; p.out_ready = 1'b1;
        s.in_valid = 1'b0; s.a = '0; s.b = '0; s.cin = 1'b0; s.out_ready = 1'b1;
`ifdef ADDER_SUB_EN
        p.sub = 1'b0;
        s.sub = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 129'(p.out_valid), 129'd0);
        check("rst_sum", {p.cout, p.sum}, 129'd0);
        check("rst_ready", 129'(p.in_ready), 129'd1);
        check("rst_valid16", 129'(s.out_valid), 129'd0);
        rst = 1'b0;

        // all-ones + 0 + cin wraps to zero with carry out
        drive('1, '0, 1'b1);
        cycle();
        p.in_valid = 1'b0;
        wait_out(lat);
        check("t1_lat", 129'(lat), 129'd16);
        check("t1_sum", {p.cout, p.sum}, {1'b1, 128'd0});
        cycle();
        check("t1_once", 129'(p.out_valid), 129'd0);

        // 32 back-to-back ops
        pops = 0;
        for (int i = 0; i < 32; i++) begin
            case (i)
                0: drive('1, '1, 1'b1);
                1: drive('0, '0, 1'b0);
                2: drive({64'd0, 64'hFFFF_FFFF_FFFF_FFFF}, 128'd1, 1'b0);
                3: drive({8'h80, 120'd0}, {8'h80, 120'd0}, 1'b1);
                default: drive({$urandom, $urandom, $urandom, $urandom},
                               {$urandom, $urandom, $urandom, $urandom}, 1'($urandom));
            endcase
            #1;
            check("t2_ready", 129'(p.in_ready), 129'd1);
            cycle();
        end
        p.in_valid = 1'b0;
        n = 0;
        while (q.size() > 0 && n < 40) begin
            cycle();
            n++;
        end
        check("t2_drain", 129'(n), 129'd16);
        check("t2_pops", 129'(pops), 129'd32);

        // backpressure with 8 ops in flight
        pops = 0;
        for (int i = 0; i < 8; i++) begin
            drive({$urandom, $urandom, $urandom, $urandom}, {96'd0, $urandom}, 1'(i));
            cycle();
        end
        p.in_valid = 1'b0;
        wait_out(lat);
        check("t3_first", 129'(lat), 129'd9);
        p.out_ready = 1'b0;
        drive(128'hDEAD, 128'hBEEF, 1'b1);
        for (int i = 0; i < 10; i++) begin
            #1;
            check("t3_ready", 129'(p.in_ready), 129'd0);
            cycle();
            check("t3_valid", 129'(p.out_valid), 129'd1);
            check("t3_hold", {p.cout, p.sum}, q[0]);
        end
        p.in_valid = 1'b0;
        p.out_ready = 1'b1;
        n = 0;
        while (q.size() > 0 && n < 40) begin
            cycle();
            n++;
        end
        check("t3_pops", 129'(pops), 129'd8);

        // reset mid-flight discards everything
        for (int i = 0; i < 5; i++) begin
            drive({4{$urandom}}, {4{$urandom}}, 1'b1);
            cycle();
        end
        p.in_valid = 1'b0;
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        q.delete();
        check("t4_valid", 129'(p.out_valid), 129'd0);
        check("t4_sum", {p.cout, p.sum}, 129'd0);
        ghost = 0;
        repeat (30) begin
            if (p.out_valid) ghost++;
            cycle();
        end
        check("t4_ghost", 129'(ghost), 129'd0);
        drive(128'd123, 128'd456, 1'b1);
        cycle();
        p.in_valid = 1'b0;
        wait_out(lat);
        check("t4_lat", 129'(lat), 129'd16);
        check("t4_sum2", {p.cout, p.sum}, 129'd580);
        cycle();

        // single-stage build: latency 1
        s.a = 16'hFFFF; s.b = 16'h0001; s.cin = 1'b0; s.in_valid = 1'b1;
        @(posedge clk);
        #1;
        s.a = 16'h1234; s.b = 16'h4321; s.cin = 1'b1;
        check("t5_valid", 129'(s.out_valid), 129'd1);
        check("t5_sum", 129'({s.cout, s.sum}), 129'h10000);
        @(posedge clk);
        #1;
        s.in_valid = 1'b0;
        check("t5_sum2", 129'({s.cout, s.sum}), 129'h05556);
        @(posedge clk);
        #1;
        check("t5_once", 129'(s.out_valid), 129'd0);

`ifdef ADDER_SUB_EN
        p.sub = 1'b1;
        drive(128'd5, 128'd7, 1'b1);
        cycle();
        p.in_valid = 1'b0;
        wait_out(lat);
        check("t6_neg", {p.cout, p.sum}, {1'b0, ~128'd1});
        cycle();
        drive(128'd7, 128'd5, 1'b0);
        cycle();
        p.in_valid = 1'b0;
        wait_out(lat);
        check("t6_pos", {p.cout, p.sum}, {1'b1, 128'd2});
        cycle();
        p.sub = 1'b0;
`endif

        check("q_empty", 129'(q.size()), 129'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
